// File: rtl/byte_add_pkg.sv
// Shared definitions for the byte-serial add/subtract controller and its adder.
package byte_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_add_unit.sv
// Combinational 8-bit adder that also exposes the carry into bit 7,
// so the controller can form signed overflow on the most significant byte.
module byte_add_unit
  import byte_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  output logic              c7
);

  logic [BYTE_W-1:0] low_sum;

  // The low seven bits are summed with one spare bit whose value is the carry into bit 7.
  assign low_sum = {1'b0, a[BYTE_W-2:0]} + {1'b0, b[BYTE_W-2:0]} + {{(BYTE_W-1){1'b0}}, cin};
  assign c7      = low_sum[BYTE_W-1];
  assign sum     = {a[BYTE_W-1] ^ b[BYTE_W-1] ^ c7, low_sum[BYTE_W-2:0]};
  assign cout    = (a[BYTE_W-1] & b[BYTE_W-1]) | (a[BYTE_W-1] & c7) | (b[BYTE_W-1] & c7);

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Multi-byte add/subtract sequenced over one shared 8-bit adder, LSB first,
// with the carry chained through a register between cycles.
module byte_serial_add_ctrl
  import byte_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [BYTE_W*NBYTES-1:0] op_a,
  input  logic [BYTE_W*NBYTES-1:0] op_b,
  input  logic                     sub,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     carry_out,
  output logic                     overflow
);

  localparam int                 W        = BYTE_W * NBYTES;
  localparam int                 IDX_W    = $clog2(NBYTES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [W-1:0]     result_q,    result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;

  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;
  logic              add_c7;

  // Operands shift right each RUN cycle, so the current byte is always the low byte.
  byte_add_unit u_add (
    .a    (a_q[BYTE_W-1:0]),
    .b    (b_q[BYTE_W-1:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout),
    .c7   (add_c7)
  );

  // NOTE: every signal gets its default first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> BYTE_W;
        b_d     = b_q >> BYTE_W;
        carry_d = add_cout;
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) result_d[i*BYTE_W +: BYTE_W] = add_sum;
        end
        if (idx_q == LAST_IDX) begin
          carry_out_d = add_cout;
          overflow_d  = add_c7 ^ add_cout;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed self-checking bench for byte_serial_add_ctrl with NBYTES=4.
module tb_byte_serial_add_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  byte_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, check its 4-cycle latency, its result flags, and the return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_o, input logic release_now);
    check({tag, " ready_before"}, 64'(start_ready), 64'd1);
    op_a        = a;
    op_b        = b;
    sub         = s;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    check({tag, " ready_in_run"}, 64'(start_ready), 64'd0);
    for (int k = 1; k <= NBYTES; k++) begin
      @(posedge clk); #1;
      if (k < NBYTES) check({tag, " valid_early"}, 64'(res_valid), 64'd0);
      else            check({tag, " valid_at_latency"}, 64'(res_valid), 64'd1);
    end
    check({tag, " result"},    64'(result),    64'(exp_r));
    check({tag, " carry_out"}, 64'(carry_out), 64'(exp_c));
    check({tag, " overflow"},  64'(overflow),  64'(exp_o));
    if (release_now) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({tag, " idle_ready"}, 64'(start_ready), 64'd1);
      check({tag, " idle_valid"}, 64'(res_valid),   64'd0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    res_ready   = 1'b0;

    #12;
    check("reset start_ready", 64'(start_ready), 64'd1);
    check("reset res_valid",   64'(res_valid),   64'd0);
    check("reset result",      64'(result),      64'd0);
    check("reset carry_out",   64'(carry_out),   64'd0);
    check("reset overflow",    64'(overflow),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic_add",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    run_op("full_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("ovf_add",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    run_op("ovf_sub",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    run_op("sub_equal",  32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: hold DONE while the requester side churns.
    run_op("bp_op", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      start_valid = ~start_valid;
      op_a        = $urandom;
      op_b        = $urandom;
      sub         = k[0];
      @(posedge clk); #1;
      check("bp result",      64'(result),      64'h2345_6789);
      check("bp carry_out",   64'(carry_out),   64'd0);
      check("bp overflow",    64'(overflow),    64'd0);
      check("bp res_valid",   64'(res_valid),   64'd1);
      check("bp start_ready", 64'(start_ready), 64'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp release start_ready", 64'(start_ready), 64'd1);
    check("bp release res_valid",   64'(res_valid),   64'd0);
    @(posedge clk); #1;
    check("bp no accept start_ready", 64'(start_ready), 64'd1);
    check("bp no accept res_valid",   64'(res_valid),   64'd0);

    // Reset mid-RUN after byte 2 has been computed (edge 3 after acceptance).
    op_a        = 32'h89AB_CDEF;
    op_b        = 32'h0123_4567;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    check("mid_run still busy", 64'(start_ready), 64'd0);
    rst_n = 1'b0;
    #2;
    check("mid_rst start_ready", 64'(start_ready), 64'd1);
    check("mid_rst res_valid",   64'(res_valid),   64'd0);
    check("mid_rst result",      64'(result),      64'd0);
    check("mid_rst carry_out",   64'(carry_out),   64'd0);
    check("mid_rst overflow",    64'(overflow),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("post_rst res_valid",   64'(res_valid),   64'd0);
      check("post_rst start_ready", 64'(start_ready), 64'd1);
    end

    run_op("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
